round_sequencer: RTL and testbench

//  Game-flow controller for the two-player bomb game. Sequences each round: clears the

---
 rtl/game_pkg.sv | 40 ++++
 rtl/sec_timer.sv | 32 +++
 rtl/round_sequencer.sv | 179 +++++++++++++++++
 tb/tb_round_sequencer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and codes for the bomb-game round sequencer.
// Latency: n/a (types and a pure decode function only).
// Backpressure: n/a.
package game_pkg;

  typedef enum logic [2:0] {
    PH_IDLE      = 3'd0,
    PH_CLEAR     = 3'd1,
    PH_COUNT     = 3'd2,
    PH_PLAY      = 3'd3,
    PH_SETTLE    = 3'd4,
    PH_RESULT    = 3'd5,
    PH_MATCH_END = 3'd6
  } phase_t;

  // Gameover codes: which player(s) died
  localparam logic [1:0] GO_NONE = 2'b00;
  localparam logic [1:0] GO_P1   = 2'b01;
  localparam logic [1:0] GO_P2   = 2'b10;
  localparam logic [1:0] GO_BOTH = 2'b11;

  // Round winner codes
  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  // The survivor wins: a dead p1 means p2 takes the round and vice versa
  function automatic logic [1:0] winner_of(input logic [1:0] code);
    logic [1:0] w;
    case (code)
      GO_P1:   w = WIN_P2;
      GO_P2:   w = WIN_P1;
      GO_BOTH: w = WIN_DRAW;
      default: w = WIN_NONE;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/sec_timer.sv
// One-second tick generator: pulses once every TICKS_PER_SEC cycles.
// Latency: first pulse TICKS_PER_SEC cycles after restart drops.
// Backpressure: none; restart simply zeroes the phase of the prescaler.
module sec_timer #(
  parameter int TICKS_PER_SEC = 30
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic sec_pulse
);

  localparam int W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [W-1:0] LAST = W'(TICKS_PER_SEC - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Wrap at the last tick of the second, or rephase on restart
  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (restart || (cnt_q == LAST)) cnt_d = '0;
  end

  // Prescaler register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign sec_pulse = (cnt_q == LAST);

endmodule

// File: rtl/round_sequencer.sv
// Round/match flow controller: clear, countdown, play, settle, result, match end.
// Latency: all outputs registered; they reflect a new phase on the edge that enters it.
// Backpressure: none; i_start/i_abort are pulses, i_abort has priority over everything.
module round_sequencer
  import game_pkg::*;
#(
  parameter int TICKS_PER_SEC = 30,
  parameter int CLEAR_CYCLES  = 2,
  parameter int COUNT_SEC     = 3,
  parameter int ROUND_SEC     = 120,
  parameter int SETTLE_CYCLES = 2,
  parameter int RESULT_SEC    = 3,
  parameter int WIN_SCORE     = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic       i_abort,
  input  logic [1:0] i_gameover,
  output logic [2:0] o_phase,
  output logic       o_round_clear,
  output logic       o_play_en,
  output logic [3:0] o_countdown,
  output logic [7:0] o_time_left,
  output logic [2:0] o_p1_score,
  output logic [2:0] o_p2_score,
  output logic [1:0] o_round_winner,
  output logic       o_match_over
);

  localparam logic [3:0] CD_INIT  = 4'(COUNT_SEC);
  localparam logic [7:0] TL_INIT  = 8'(ROUND_SEC);
  localparam logic [7:0] RES_INIT = 8'(RESULT_SEC);
  localparam logic [7:0] CLR_LAST = 8'(CLEAR_CYCLES - 1);
  localparam logic [7:0] SET_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [2:0] WIN_MAX  = 3'(WIN_SCORE);

  phase_t     state_q, state_d;
  logic       sec_pulse, entering;
  logic [7:0] cyc_q, cyc_d;
  logic [3:0] countdown_q, countdown_d;
  logic [7:0] time_left_q, time_left_d;
  logic [7:0] res_left_q, res_left_d;
  logic [1:0] code_q, code_d;
  logic [1:0] winner_q, winner_d;
  logic [2:0] p1_score_q, p1_score_d;
  logic [2:0] p2_score_q, p2_score_d;
  logic       round_clear_q, round_clear_d;
  logic       play_en_q, play_en_d;
  logic       match_over_q, match_over_d;

  // Any phase change rephases the prescaler so each phase's first second is full length
  assign entering = (state_d != state_q);

  sec_timer #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_sec_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart  (entering),
    .sec_pulse(sec_pulse)
  );

  // Phase register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= PH_IDLE;
    else        state_q <= state_d;
  end

  // Phase transitions; abort overrides every other cause, including a same-cycle start
  always_comb begin
    state_d = state_q;
    case (state_q)
      PH_IDLE:      if (i_start) state_d = PH_CLEAR;
      PH_CLEAR:     if (cyc_q == CLR_LAST) state_d = PH_COUNT;
      PH_COUNT:     if (sec_pulse && (countdown_q == 4'd1)) state_d = PH_PLAY;
      PH_PLAY: begin
        // A death on the time-out cycle still counts as a death
        if (i_gameover != GO_NONE)                     state_d = PH_SETTLE;
        else if (sec_pulse && (time_left_q == 8'd1))   state_d = PH_RESULT;
      end
      PH_SETTLE:    if (cyc_q == SET_LAST) state_d = PH_RESULT;
      PH_RESULT: begin
        if (sec_pulse && (res_left_q == 8'd1))
          state_d = ((p1_score_q == WIN_MAX) || (p2_score_q == WIN_MAX)) ? PH_MATCH_END : PH_CLEAR;
      end
      PH_MATCH_END: if (i_start) state_d = PH_CLEAR;
      default:      state_d = PH_IDLE;
    endcase
    if (i_abort) state_d = PH_IDLE;
  end

  // Counters, latched gameover code, scores and decoded output flags for the next phase
  always_comb begin
    cyc_d = 8'd0;
    if (!entering && ((state_q == PH_CLEAR) || (state_q == PH_SETTLE))) cyc_d = cyc_q + 8'd1;

    countdown_d = 4'd0;
    if (state_d == PH_COUNT)
      countdown_d = entering ? CD_INIT : (sec_pulse ? countdown_q - 4'd1 : countdown_q);

    // Time left freezes through SETTLE so the display shows when the death happened
    time_left_d = 8'd0;
    if (state_d == PH_PLAY)
      time_left_d = entering ? TL_INIT : (sec_pulse ? time_left_q - 8'd1 : time_left_q);
    else if (state_d == PH_SETTLE)
      time_left_d = time_left_q;

    res_left_d = 8'd0;
    if (state_d == PH_RESULT)
      res_left_d = entering ? RES_INIT : (sec_pulse ? res_left_q - 8'd1 : res_left_q);

    // Accumulate deaths so a second explosion tick can still turn a win into a draw
    code_d = GO_NONE;
    if (state_d == PH_SETTLE) code_d = entering ? i_gameover : (code_q | i_gameover);

    winner_d = WIN_NONE;
    if (state_d == PH_RESULT) begin
      if (!entering)                    winner_d = winner_q;
      else if (state_q == PH_SETTLE)    winner_d = winner_of(code_q | i_gameover);
      else                              winner_d = WIN_DRAW;
    end else if (state_d == PH_MATCH_END) begin
      winner_d = winner_q;
    end

    p1_score_d = p1_score_q;
    p2_score_d = p2_score_q;
    if (entering && (state_d == PH_RESULT)) begin
      if ((winner_d == WIN_P1) && (p1_score_q < WIN_MAX)) p1_score_d = p1_score_q + 3'd1;
      if ((winner_d == WIN_P2) && (p2_score_q < WIN_MAX)) p2_score_d = p2_score_q + 3'd1;
    end
    if ((state_d == PH_IDLE) || ((state_q == PH_MATCH_END) && (state_d == PH_CLEAR))) begin
      p1_score_d = 3'd0;
      p2_score_d = 3'd0;
    end

    round_clear_d = (state_d == PH_CLEAR);
    play_en_d     = (state_d == PH_PLAY);
    match_over_d  = (state_d == PH_MATCH_END);
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q         <= 8'd0;
      countdown_q   <= 4'd0;
      time_left_q   <= 8'd0;
      res_left_q    <= 8'd0;
      code_q        <= GO_NONE;
      winner_q      <= WIN_NONE;
      p1_score_q    <= 3'd0;
      p2_score_q    <= 3'd0;
      round_clear_q <= 1'b0;
      play_en_q     <= 1'b0;
      match_over_q  <= 1'b0;
    end else begin
      cyc_q         <= cyc_d;
      countdown_q   <= countdown_d;
      time_left_q   <= time_left_d;
      res_left_q    <= res_left_d;
      code_q        <= code_d;
      winner_q      <= winner_d;
      p1_score_q    <= p1_score_d;
      p2_score_q    <= p2_score_d;
      round_clear_q <= round_clear_d;
      play_en_q     <= play_en_d;
      match_over_q  <= match_over_d;
    end
  end

  assign o_phase        = state_q;
  assign o_round_clear  = round_clear_q;
  assign o_play_en      = play_en_q;
  assign o_countdown    = countdown_q;
  assign o_time_left    = time_left_q;
  assign o_p1_score     = p1_score_q;
  assign o_p2_score     = p2_score_q;
  assign o_round_winner = winner_q;
  assign o_match_over   = match_over_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Self-checking bench for round_sequencer against an elapsed-time model of the game flow.
// Latency: compares every output 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_round_sequencer;
  import game_pkg::*;

  localparam int T   = 4;
  localparam int CS  = 3;
  localparam int RS  = 5;
  localparam int WS  = 2;
  localparam int CC  = 2;
  localparam int SC  = 2;
  localparam int RES = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_start = 1'b0;
  logic       i_abort = 1'b0;
  logic [1:0] i_gameover = 2'b00;
  logic [2:0] o_phase;
  logic       o_round_clear, o_play_en, o_match_over;
  logic [3:0] o_countdown;
  logic [7:0] o_time_left;
  logic [2:0] o_p1_score, o_p2_score;
  logic [1:0] o_round_winner;
  logic [25:0] dut_bus;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  round_sequencer #(
    .TICKS_PER_SEC(T), .CLEAR_CYCLES(CC), .COUNT_SEC(CS), .ROUND_SEC(RS),
    .SETTLE_CYCLES(SC), .RESULT_SEC(RES), .WIN_SCORE(WS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort), .i_gameover(i_gameover),
    .o_phase(o_phase), .o_round_clear(o_round_clear), .o_play_en(o_play_en),
    .o_countdown(o_countdown), .o_time_left(o_time_left), .o_p1_score(o_p1_score),
    .o_p2_score(o_p2_score), .o_round_winner(o_round_winner), .o_match_over(o_match_over)
  );

  assign dut_bus = {o_phase, o_round_clear, o_play_en, o_countdown, o_time_left,
                    o_p1_score, o_p2_score, o_round_winner, o_match_over};

  // Reference model: current phase plus cycles elapsed in it; display values are derived arithmetically
  phase_t     m_ph;
  int         m_el, m_frozen, m_s1, m_s2;
  logic [1:0] m_code, m_win;

  task automatic model_reset();
    m_ph = PH_IDLE; m_el = 0; m_frozen = 0; m_s1 = 0; m_s2 = 0; m_code = 2'b00; m_win = 2'b00;
  endtask

  function automatic logic [25:0] exp_bus();
    int cd = 0;
    int tl = 0;
    logic [1:0] w = 2'b00;
    if (m_ph == PH_COUNT)  cd = CS - m_el / T;
    if (m_ph == PH_PLAY)   tl = RS - m_el / T;
    if (m_ph == PH_SETTLE) tl = m_frozen;
    if (m_ph == PH_RESULT || m_ph == PH_MATCH_END) w = m_win;
    return {m_ph, m_ph == PH_CLEAR, m_ph == PH_PLAY, 4'(cd), 8'(tl),
            3'(m_s1), 3'(m_s2), w, m_ph == PH_MATCH_END};
  endfunction

  task automatic model_step(input logic s, input logic a, input logic [1:0] g);
    phase_t nx = m_ph;
    case (m_ph)
      PH_IDLE:  if (s) nx = PH_CLEAR;
      PH_CLEAR: if (m_el + 1 == CC) nx = PH_COUNT;
      PH_COUNT: if (m_el + 1 == CS * T) nx = PH_PLAY;
      PH_PLAY: begin
        if (g != 2'b00) begin
          nx = PH_SETTLE; m_code = g; m_frozen = RS - m_el / T;
        end else if (m_el + 1 == RS * T) begin
          nx = PH_RESULT; m_win = 2'b11;
        end
      end
      PH_SETTLE: begin
        m_code = m_code | g;
        if (m_el + 1 == SC) begin
          nx = PH_RESULT;
          if (m_code == 2'b01) begin m_win = 2'b10; if (m_s2 < WS) m_s2++; end
          else if (m_code == 2'b10) begin m_win = 2'b01; if (m_s1 < WS) m_s1++; end
          else m_win = 2'b11;
        end
      end
      PH_RESULT: if (m_el + 1 == RES * T) nx = (m_s1 == WS || m_s2 == WS) ? PH_MATCH_END : PH_CLEAR;
      PH_MATCH_END: if (s) begin nx = PH_CLEAR; m_s1 = 0; m_s2 = 0; m_win = 2'b00; end
      default: nx = PH_IDLE;
    endcase
    if (a) begin nx = PH_IDLE; m_s1 = 0; m_s2 = 0; m_win = 2'b00; end
    m_el = (nx != m_ph) ? 0 : m_el + 1;
    m_ph = nx;
  endtask

  task automatic tick(input logic s, input logic a, input logic [1:0] g);
    i_start = s; i_abort = a; i_gameover = g;
    @(posedge clk);
    model_step(s, a, g);
    #1;
    i_start = 1'b0; i_abort = 1'b0; i_gameover = 2'b00;
  endtask

  // Idle-input ticks until the DUT shows phase ph, comparing against the model every cycle
  task automatic run_to(input phase_t ph, input int budget, input string tag);
    int n = 0;
    while (o_phase !== ph && n < budget) begin
      tick(1'b0, 1'b0, 2'b00); n++;
      checks++;
      if (dut_bus !== exp_bus()) begin
        errors++; $display("FAIL %s_model got=%h exp=%h", tag, dut_bus, exp_bus());
      end
    end
    checks++;
    if (o_phase !== ph) begin
      errors++; $display("FAIL %s_timeout phase got=%0d exp=%0d", tag, o_phase, ph);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (dut_bus !== 26'd0) begin errors++; $display("FAIL reset_hold got=%h exp=0", dut_bus); end
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick(1'b0, 1'b0, 2'b00);
      checks++;
      if (dut_bus !== exp_bus()) begin errors++; $display("FAIL reset_idle got=%h exp=%h", dut_bus, exp_bus()); end
    end
    checks++;
    if (o_phase !== PH_IDLE || dut_bus !== 26'd0) begin
      errors++; $display("FAIL idle_after_50 got=%h exp=0", dut_bus);
    end
  endtask

  task automatic test_round_start();
    int clr = 0, n3 = 0, n2 = 0, n1 = 0, first_cd = -1, first_play = -1;
    for (int i = 0; i < 16; i++) begin
      tick(i == 0, 1'b0, 2'b00);
      checks++;
      if (dut_bus !== exp_bus()) begin errors++; $display("FAIL start_model got=%h exp=%h", dut_bus, exp_bus()); end
      if (o_round_clear === 1'b1) clr++;
      if (o_countdown === 4'd3) begin n3++; if (first_cd < 0) first_cd = i; end
      if (o_countdown === 4'd2) n2++;
      if (o_countdown === 4'd1) n1++;
      if (o_play_en === 1'b1 && first_play < 0) first_play = i;
    end
    checks++;
    if (clr != 2) begin errors++; $display("FAIL clear_len got=%0d exp=2", clr); end
    checks++;
    if (n3 != 4 || n2 != 4 || n1 != 4) begin
      errors++; $display("FAIL countdown_len got=%0d,%0d,%0d exp=4,4,4", n3, n2, n1);
    end
    checks++;
    if (first_cd != 2 || first_play - first_cd != 12) begin
      errors++; $display("FAIL play_en_at got=%0d,%0d exp=2,14", first_cd, first_play);
    end
  endtask

  task automatic test_p1_dead();
    tick(1'b0, 1'b0, 2'b00);
    tick(1'b0, 1'b0, 2'b01);
    checks++;
    if (o_play_en !== 1'b0 || o_phase !== PH_SETTLE) begin
      errors++; $display("FAIL p1dead_play_en got=%b/%0d exp=0/%0d", o_play_en, o_phase, PH_SETTLE);
    end
    checks++;
    if (dut_bus !== exp_bus()) begin errors++; $display("FAIL p1dead_model got=%h exp=%h", dut_bus, exp_bus()); end
    run_to(PH_RESULT, 4, "p1dead_settle");
    checks++;
    if (o_round_winner !== 2'b10 || o_p2_score !== 3'd1 || o_p1_score !== 3'd0) begin
      errors++; $display("FAIL p1dead_result got=%b,%0d,%0d exp=10,0,1", o_round_winner, o_p1_score, o_p2_score);
    end
    run_to(PH_PLAY, 40, "p1dead_next");
  endtask

  task automatic test_both_dead();
    tick(1'b0, 1'b0, 2'b10);
    tick(1'b0, 1'b0, 2'b11);
    checks++;
    if (dut_bus !== exp_bus()) begin errors++; $display("FAIL both_settle got=%h exp=%h", dut_bus, exp_bus()); end
    tick(1'b0, 1'b0, 2'b00);
    checks++;
    if (o_phase !== PH_RESULT || o_round_winner !== 2'b11 || o_p1_score !== 3'd0 || o_p2_score !== 3'd1) begin
      errors++; $display("FAIL both_draw got=%0d,%b,%0d,%0d exp=5,11,0,1", o_phase, o_round_winner, o_p1_score, o_p2_score);
    end
    run_to(PH_PLAY, 40, "both_next");
  endtask

  task automatic test_timeout_match();
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'b0, 2'b00);
      checks++;
      if (dut_bus !== exp_bus()) begin errors++; $display("FAIL timeout_model got=%h exp=%h", dut_bus, exp_bus()); end
    end
    checks++;
    if (o_phase !== PH_RESULT || o_round_winner !== 2'b11 || o_p1_score !== 3'd0 || o_p2_score !== 3'd1) begin
      errors++; $display("FAIL timeout_draw got=%0d,%b,%0d,%0d exp=5,11,0,1", o_phase, o_round_winner, o_p1_score, o_p2_score);
    end
    for (int r = 1; r <= 2; r++) begin
      run_to(PH_PLAY, 40, "match_play");
      tick(1'b0, 1'b0, 2'b10);
      run_to(PH_RESULT, 4, "match_settle");
      checks++;
      if (o_round_winner !== 2'b01 || o_p1_score !== 3'(r)) begin
        errors++; $display("FAIL p1_win got=%b,%0d exp=01,%0d", o_round_winner, o_p1_score, r);
      end
    end
    run_to(PH_MATCH_END, 16, "match_end");
    checks++;
    if (o_match_over !== 1'b1 || o_round_winner !== 2'b01 || o_p1_score !== 3'd2 || o_p2_score !== 3'd1) begin
      errors++; $display("FAIL match_over got=%b,%b,%0d,%0d exp=1,01,2,1", o_match_over, o_round_winner, o_p1_score, o_p2_score);
    end
    tick(1'b1, 1'b0, 2'b00);
    checks++;
    if (o_phase !== PH_CLEAR || o_round_clear !== 1'b1 || o_p1_score !== 3'd0 || o_p2_score !== 3'd0 || o_round_winner !== 2'b00) begin
      errors++; $display("FAIL restart got=%h exp phase=1 clear=1 scores=0", dut_bus);
    end
  endtask

  task automatic test_abort();
    run_to(PH_PLAY, 40, "abort_play");
    tick(1'b0, 1'b0, 2'b01);
    run_to(PH_COUNT, 30, "abort_count");
    tick(1'b0, 1'b0, 2'b00);
    tick(1'b1, 1'b1, 2'b00);
    checks++;
    if (o_phase !== PH_IDLE || o_p2_score !== 3'd0 || o_countdown !== 4'd0) begin
      errors++; $display("FAIL abort got=%0d,%0d,%0d exp=0,0,0", o_phase, o_p2_score, o_countdown);
    end
    repeat (3) tick(1'b0, 1'b0, 2'b00);
    checks++;
    if (dut_bus !== 26'd0 || dut_bus !== exp_bus()) begin
      errors++; $display("FAIL abort_start_ignored got=%h exp=0", dut_bus);
    end
    // Asynchronous reset in the middle of a round
    tick(1'b1, 1'b0, 2'b00);
    run_to(PH_COUNT, 10, "arst_count");
    @(negedge clk);
    rst_n = 1'b0; model_reset();
    #1;
    checks++;
    if (dut_bus !== 26'd0) begin errors++; $display("FAIL async_reset got=%h exp=0", dut_bus); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    int seen_match = 0;
    for (int i = 0; i < 4000; i++) begin
      logic s, a;
      logic [1:0] g;
      s = ($urandom_range(0, 19) == 0);
      a = ($urandom_range(0, 299) == 0);
      g = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      tick(s, a, g);
      if (o_match_over === 1'b1) seen_match++;
      checks++;
      if (dut_bus !== exp_bus()) begin
        errors++; $display("FAIL random_cyc%0d got=%h exp=%h", i, dut_bus, exp_bus());
      end
    end
  endtask

  initial begin
    test_reset();
    test_round_start();
    test_p1_dead();
    test_both_dead();
    test_timeout_match();
    test_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
